mem_access_unit: RTL
====================

# mem_access_unit

Load/store unit sitting between the MIPS32 pipeline's MEM stage and the word-addressed data memory. Accepts byte, halfword and word load/store requests at byte addresses. Drives the memory's word interface, including read-modify-write for sub-word stores and lane extraction with sign/zero extension for loads. Misaligned and out-of-range accesses are reported instead of issued to memory.

## Interface
- `ADDR_W`, default 11: data-memory word-address width; addressable space is 4·2^ADDR_W bytes.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; a request is accepted on a rising edge with `req_valid & req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed`  in  1  loads only: 1 sign-extends, 0 zero-extends.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  load result, valid with `rsp_valid`; 0 for stores and errors.
- `rsp_error`  out  1  valid with `rsp_valid`: access was misaligned, illegal-size or out of range.
- `mem_addr`  out  ADDR_W  word address to memory.
- `mem_wdata`  out  32  write word to memory.
- `mem_write`  out  1  memory write enable; memory writes on the rising edge.
- `mem_read`  out  1  memory read enable; `mem_rdata` is combinational from `mem_addr` while high.
- `mem_rdata`  in  32  memory read word.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP. `req_ready` = (state == IDLE).
- On accept, latch all request fields. Word address = `req_addr[ADDR_W+1:2]`; lane = `req_addr[1:0]`.
- Error check at accept: size 11; half with `addr[0]`=1; word with `addr[1:0]`≠0; any of `req_addr[31:ADDR_W+2]` nonzero. On error: IDLE→RESP with `rsp_error`=1. No memory access occurs.
- Lanes are little-endian: byte k = bits [8k+7:8k]; half h (`addr[1]`) = bits [16h+15:16h].
- Load: IDLE→LOAD. `mem_read`=1. At the edge, the selected lane is extended per `req_signed` into the response register. LOAD→RESP.
- Word store: IDLE→STORE. `mem_write`=1 with `mem_wdata`=`req_wdata`. STORE→RESP.
- Sub-word store: IDLE→RMW_RD. `mem_read`=1. At the edge, latch `mem_rdata` with the target lane replaced by `req_wdata[7:0]`/`[15:0]`. RMW_RD→RMW_WR. `mem_write`=1 with the merged word. RMW_WR→RESP.
- RESP: `rsp_valid`=1 for exactly one cycle. RESP→IDLE unconditionally; there is no response back-pressure.
- `mem_read` and `mem_write` are decoded combinationally from state and are never high together. Outside their states they are 0.
- `mem_wdata` is 0 whenever `mem_write`=0.
- `mem_addr` is driven from the latched word address at all times.
- `req_valid` held high while busy is ignored. Exactly one transaction occurs per handshake.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `mem_addr`=0, `mem_wdata`=0, `mem_write`=0, `mem_read`=0.
- Latency counts from the accept edge E0 to the cycle with `rsp_valid` high:
  - load / word store: cycle E0+2 (3-cycle occupancy);
  - sub-word store: cycle E0+3 (4-cycle occupancy);
  - error: cycle E0+1.
- The next accept is possible on the edge ending RESP+1 (the first IDLE cycle).
- Reset mid-operation: asserting `rst_n` low forces IDLE and clears outputs immediately. If reset is asserted during RMW_WR or STORE before the edge, `mem_write` is already 0 and memory is unchanged. No `rsp_valid` is produced for the aborted request.
- Requests presented while `rst_n`=0 are not accepted.

## Test plan
- sw 0xDEADBEEF @0x10, then lw @0x10 -> memory word 4 = 0xDEADBEEF. The load returns 0xDEADBEEF with `rsp_valid` at E0+2 and `rsp_error`=0.
- Preload word 4 = 0x11223344. sb 0xA5 @0x13 -> word 4 = 0xA5223344, response at E0+3. lb @0x13 -> 0xFFFFFFA5. lbu @0x13 -> 0x000000A5. lbu @0x10 -> 0x00000044.
- Preload word 8 = 0. sh 0x8001 @0x22 -> word 8 = 0x80010000. lh @0x22 -> 0xFFFF8001. lhu @0x22 -> 0x00008001. lh @0x20 -> 0x00000000.
- Each of the following -> `rsp_error`=1, `rsp_rdata`=0, response at E0+1, and `mem_read`/`mem_write` never asserted:
  - lw @0x6;
  - sh @0x21;
  - size 11;
  - lw @0x2000 (with ADDR_W=11).
- `req_valid` held high over 3 alternating loads/stores -> `req_ready` low in all non-IDLE states; exactly 3 `rsp_valid` pulses; memory matches the reference model.
- Preload word 4 = 0x11223344. sb 0xFF @0x10, with `rst_n` asserted during RMW_WR -> word 4 remains 0x11223344. No `rsp_valid` pulse. `req_ready`=1 immediately. The next lw @0x10 returns 0x11223344.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the MEM stage and a word-addressed data memory.
// Handles byte/half/word accesses at byte addresses, read-modify-write for sub-word stores,
// sign/zero extension for loads, and reports misaligned/illegal/out-of-range requests
// without touching memory.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStore,
    StRmwRd,
    StRmwWr,
    StResp
  } state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeBad  = 2'b11;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         merge_q, merge_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                error_q, error_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic                req_err;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         load_ext;
  logic [31:0]         merged;

  // Classify the incoming request: any alignment, size or range violation is an error.
  always_comb begin
    req_err = 1'b0;
    if (req_size == SizeBad)                              req_err = 1'b1;
    if ((req_size == SizeHalf) && req_addr[0])            req_err = 1'b1;
    if ((req_size == SizeWord) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    // Address bits above the byte range of the memory must be zero.
    if ((req_addr >> (ADDR_W + 2)) != 32'd0)              req_err = 1'b1;
  end

  // Extract the addressed lane of the read word and extend it to 32 bits.
  always_comb begin
    rd_byte = mem_rdata[7:0];
    unique case (lane_q)
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      2'd3: rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      SizeByte: load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      SizeHalf: load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default:  load_ext = mem_rdata;
    endcase
  end

  // Replace the target lane of the read word with the right-aligned store data.
  always_comb begin
    merged = mem_rdata;
    if (size_q == SizeByte) begin
      unique case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged[7:0] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Next-state logic: sequence one transaction per handshake.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    size_d      = size_q;
    signed_d    = signed_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d   = req_addr[ADDR_W+1:2];
          lane_d   = req_addr[1:0];
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = 32'd0;
          error_d  = 1'b0;
          if (req_err) begin
            error_d     = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end else if (!req_write) begin
            state_d = StLoad;
          end else if (req_size == SizeWord) begin
            state_d = StStore;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLoad: begin
        rdata_d     = load_ext;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StStore: begin
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StRmwRd: begin
        merge_d = merged;
        state_d = StRmwWr;
      end
      StRmwWr: begin
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        // Response fields are only meaningful during the pulse; clear them afterwards.
        rdata_d = 32'd0;
        error_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched request registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      wdata_q     <= 32'd0;
      merge_q     <= 32'd0;
      rdata_q     <= 32'd0;
      error_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Memory strobes decode straight from state so reset drops them immediately.
  always_comb begin
    req_ready = (state_q == StIdle);
    mem_read  = (state_q == StLoad) || (state_q == StRmwRd);
    mem_write = (state_q == StStore) || (state_q == StRmwWr);
    mem_addr  = addr_q;
    mem_wdata = 32'd0;
    if (state_q == StStore) mem_wdata = wdata_q;
    if (state_q == StRmwWr) mem_wdata = merge_q;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rdata_q;
    rsp_error = error_q;
  end

endmodule
